// File: rtl/pc_branch_unit_if.sv
// Control and datapath bundle between the LC-3 control logic and the PC/branch unit.
// The master drives selects, loads and operands; the slave returns the PC, the effective address and the debug counters.
interface pc_branch_unit_if #(
  parameter int CNT_W = 16
);
  logic             LD_PC;
  logic             LD_BR;
  logic [1:0]       PCMUX_Sel;
  logic             ADDR1MUX_Sel;
  logic [1:0]       ADDR2MUX_Sel;
  logic [15:0]      IR_Val;
  logic [15:0]      SR1_Out;
  logic [15:0]      Bus_Val;
  logic             BEN_Val;
  logic [15:0]      PC;
  logic [15:0]      Addr_Out;
  logic             Br_Taken;
  logic [CNT_W-1:0] Br_Count;

  modport master (
    output LD_PC, LD_BR, PCMUX_Sel, ADDR1MUX_Sel, ADDR2MUX_Sel,
    output IR_Val, SR1_Out, Bus_Val, BEN_Val,
    input  PC, Addr_Out, Br_Taken, Br_Count
  );

  modport slave (
    input  LD_PC, LD_BR, PCMUX_Sel, ADDR1MUX_Sel, ADDR2MUX_Sel,
    input  IR_Val, SR1_Out, Bus_Val, BEN_Val,
    output PC, Addr_Out, Br_Taken, Br_Count
  );
endinterface

// File: rtl/pc_branch_unit.sv
// LC-3 program counter with the ADDR1/ADDR2 address adder, conditional branch loading,
// and a saturating taken-branch counter for debug display.
module pc_branch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  pc_branch_unit_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [15:0]      r_pc;
  logic             r_br_taken;
  logic [CNT_W-1:0] r_br_count;

  logic [15:0] w_addr1;
  logic [15:0] w_addr2;
  logic [15:0] w_addr;
  logic [15:0] w_pcmux;
  logic        w_br_take;

  assign w_addr1 = bus.ADDR1MUX_Sel ? bus.SR1_Out : r_pc;

  always_comb begin
    w_addr2 = 16'h0000;
    case (bus.ADDR2MUX_Sel)
      2'b00:   w_addr2 = 16'h0000;
      2'b01:   w_addr2 = {{10{bus.IR_Val[5]}},  bus.IR_Val[5:0]};
      2'b10:   w_addr2 = {{7{bus.IR_Val[8]}},   bus.IR_Val[8:0]};
      default: w_addr2 = {{5{bus.IR_Val[10]}},  bus.IR_Val[10:0]};
    endcase
  end

  // 16-bit sum: carry out is dropped so the address wraps modulo 2^16.
  assign w_addr = w_addr1 + w_addr2;

  // Reserved select 2'b11 reloads the current PC, so LD_PC with it is a hold.
  always_comb begin
    w_pcmux = r_pc;
    case (bus.PCMUX_Sel)
      2'b00:   w_pcmux = r_pc + 16'd1;
      2'b01:   w_pcmux = bus.Bus_Val;
      2'b10:   w_pcmux = w_addr;
      default: w_pcmux = r_pc;
    endcase
  end

  // LD_PC has priority, so a simultaneous LD_BR is neither loaded nor counted.
  assign w_br_take = bus.LD_BR & bus.BEN_Val & ~bus.LD_PC;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc       <= RESET_PC;
      r_br_taken <= 1'b0;
      r_br_count <= '0;
    end else begin
      r_br_taken <= w_br_take;
      if (bus.LD_PC) begin
        r_pc <= w_pcmux;
      end else if (w_br_take) begin
        r_pc <= w_addr;
      end
      if (w_br_take && (r_br_count != CNT_MAX)) begin
        r_br_count <= r_br_count + CNT_ONE;
      end
    end
  end

  assign bus.PC       = r_pc;
  assign bus.Addr_Out = w_addr;
  assign bus.Br_Taken = r_br_taken;
  assign bus.Br_Count = r_br_count;
endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: a vector table run on a 16-bit-counter instance,
// plus a saturation sequence on a 2-bit-counter instance with a non-zero reset PC.
module tb_pc_branch_unit;
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  pc_branch_unit_if #(.CNT_W(16)) m0 ();
  pc_branch_unit_if #(.CNT_W(2))  m1 ();

  pc_branch_unit #(.RESET_PC(16'h0000), .CNT_W(16)) dut0 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (m0.slave)
  );

  logic Reset1;
  pc_branch_unit #(.RESET_PC(16'h3000), .CNT_W(2)) dut1 (
    .Clk   (Clk),
    .Reset (Reset1),
    .bus   (m1.slave)
  );

  typedef struct {
    string       name;
    bit          rst;
    bit          ld_pc;
    bit          ld_br;
    bit          ben;
    bit [1:0]    pcmux;
    bit          a1;
    bit [1:0]    a2;
    logic [15:0] ir;
    logic [15:0] sr1;
    logic [15:0] busv;
    bit          chk_addr;
    logic [15:0] exp_addr;
    logic [15:0] exp_pc;
    bit          exp_taken;
    logic [15:0] exp_cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive0(input vec_t v);
    Reset           = v.rst;
    m0.LD_PC        = v.ld_pc;
    m0.LD_BR        = v.ld_br;
    m0.BEN_Val      = v.ben;
    m0.PCMUX_Sel    = v.pcmux;
    m0.ADDR1MUX_Sel = v.a1;
    m0.ADDR2MUX_Sel = v.a2;
    m0.IR_Val       = v.ir;
    m0.SR1_Out      = v.sr1;
    m0.Bus_Val      = v.busv;
  endtask

  task automatic drive1(input bit rst, input bit ld_br, input bit ben);
    Reset1          = rst;
    m1.LD_PC        = 1'b0;
    m1.LD_BR        = ld_br;
    m1.BEN_Val      = ben;
    m1.PCMUX_Sel    = 2'b00;
    m1.ADDR1MUX_Sel = 1'b0;
    m1.ADDR2MUX_Sel = 2'b00;
    m1.IR_Val       = 16'h0000;
    m1.SR1_Out      = 16'h0000;
    m1.Bus_Val      = 16'h0000;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    //            name        rst pc br ben pcm a1 a2  ir       sr1      bus      chkA  addr     pc       tk cnt
    vecs[0]  = '{"reset",     1, 0, 0, 0, 2'd0, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'd0};
    vecs[1]  = '{"pc_inc1",   0, 1, 0, 0, 2'd0, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0001, 0, 16'd0};
    vecs[2]  = '{"pc_inc2",   0, 1, 0, 0, 2'd0, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0001, 16'h0002, 0, 16'd0};
    vecs[3]  = '{"pc_inc3",   0, 1, 0, 0, 2'd0, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0002, 16'h0003, 0, 16'd0};
    vecs[4]  = '{"ld_3000",   0, 1, 0, 0, 2'd1, 0, 2'd0, 16'h0000, 16'h0000, 16'h3000, 1, 16'h0003, 16'h3000, 0, 16'd0};
    vecs[5]  = '{"br_taken",  0, 0, 1, 1, 2'd0, 0, 2'd2, 16'h0E05, 16'h0000, 16'h0000, 1, 16'h3005, 16'h3005, 1, 16'd1};
    vecs[6]  = '{"pulse_end", 0, 0, 0, 0, 2'd0, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1, 16'h3005, 16'h3005, 0, 16'd1};
    vecs[7]  = '{"reld_3000", 0, 1, 0, 0, 2'd1, 0, 2'd0, 16'h0000, 16'h0000, 16'h3000, 1, 16'h3005, 16'h3000, 0, 16'd1};
    vecs[8]  = '{"br_not",    0, 0, 1, 0, 2'd0, 0, 2'd2, 16'h0E05, 16'h0000, 16'h0000, 1, 16'h3005, 16'h3000, 0, 16'd1};
    vecs[9]  = '{"off9_neg",  0, 0, 0, 0, 2'd0, 0, 2'd2, 16'h01FF, 16'h0000, 16'h0000, 1, 16'h2FFF, 16'h3000, 0, 16'd1};
    vecs[10] = '{"ld_ffff",   0, 1, 0, 0, 2'd1, 0, 2'd0, 16'h0000, 16'h0000, 16'hFFFF, 1, 16'h3000, 16'hFFFF, 0, 16'd1};
    vecs[11] = '{"pc_wrap",   0, 1, 0, 0, 2'd0, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1, 16'hFFFF, 16'h0000, 0, 16'd1};
    vecs[12] = '{"jmp",       0, 1, 0, 0, 2'd2, 1, 2'd0, 16'h0000, 16'h4000, 16'h0000, 1, 16'h4000, 16'h4000, 0, 16'd1};
    vecs[13] = '{"pc_vs_br",  0, 1, 1, 1, 2'd1, 0, 2'd2, 16'h0E05, 16'h0000, 16'h1234, 1, 16'h4005, 16'h1234, 0, 16'd1};
    vecs[14] = '{"pcmux_rsv", 0, 1, 0, 0, 2'd3, 0, 2'd0, 16'h0000, 16'h0000, 16'h5555, 1, 16'h1234, 16'h1234, 0, 16'd1};
    vecs[15] = '{"off6_neg",  0, 0, 0, 0, 2'd0, 0, 2'd1, 16'h003F, 16'h0000, 16'h0000, 1, 16'h1233, 16'h1234, 0, 16'd1};
    vecs[16] = '{"off11_wrp", 0, 0, 0, 0, 2'd0, 1, 2'd3, 16'h0400, 16'h0400, 16'h0000, 1, 16'h0000, 16'h1234, 0, 16'd1};
    vecs[17] = '{"sr1_wrap",  0, 0, 0, 0, 2'd0, 1, 2'd1, 16'h0001, 16'hFFFF, 16'h0000, 1, 16'h0000, 16'h1234, 0, 16'd1};
    vecs[18] = '{"b2b_br1",   0, 0, 1, 1, 2'd0, 0, 2'd1, 16'h0001, 16'h0000, 16'h0000, 1, 16'h1235, 16'h1235, 1, 16'd2};
    vecs[19] = '{"b2b_br2",   0, 0, 1, 1, 2'd0, 0, 2'd1, 16'h0001, 16'h0000, 16'h0000, 1, 16'h1236, 16'h1236, 1, 16'd3};
    vecs[20] = '{"rst_pulse", 1, 0, 1, 1, 2'd0, 0, 2'd1, 16'h0001, 16'h0000, 16'h0000, 1, 16'h1237, 16'h0000, 0, 16'd0};
    vecs[21] = '{"post_rst",  0, 0, 0, 0, 2'd0, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 0, 16'd0};

    drive1(1'b1, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      @(negedge Clk);
      drive0(vecs[i]);
      #1;
      if (vecs[i].chk_addr) chk({vecs[i].name, ".addr"}, m0.Addr_Out, vecs[i].exp_addr);
      @(posedge Clk);
      #1;
      chk({vecs[i].name, ".pc"},    m0.PC,                 vecs[i].exp_pc);
      chk({vecs[i].name, ".taken"}, {15'd0, m0.Br_Taken},  {15'd0, vecs[i].exp_taken});
      chk({vecs[i].name, ".count"}, m0.Br_Count,           vecs[i].exp_cnt);
      $display("[TB] vec %0d %s: addr=%h pc=%h taken=%0b count=%0d", i, vecs[i].name,
               m0.Addr_Out, m0.PC, m0.Br_Taken, m0.Br_Count);
    end

    // Saturation on the 2-bit counter: five taken branches, then a not-taken one.
    @(negedge Clk);
    drive1(1'b1, 1'b0, 1'b0);
    @(posedge Clk);
    #1;
    chk("sat.reset_pc", m1.PC, 16'h3000);
    chk("sat.reset_cnt", {14'd0, m1.Br_Count}, 16'd0);
    for (int k = 1; k <= 6; k++) begin
      logic [15:0] exp_c;
      logic        exp_t;
      exp_t = (k <= 5);
      exp_c = (k < 3) ? 16'(k) : 16'd3;
      @(negedge Clk);
      drive1(1'b0, 1'b1, exp_t);
      @(posedge Clk);
      #1;
      chk($sformatf("sat.br%0d.count", k), {14'd0, m1.Br_Count}, exp_c);
      chk($sformatf("sat.br%0d.taken", k), {15'd0, m1.Br_Taken}, {15'd0, exp_t});
      chk($sformatf("sat.br%0d.pc", k), m1.PC, 16'h3000);
      $display("[TB] sat %0d: ben=%0b pc=%h taken=%0b count=%0d", k, exp_t,
               m1.PC, m1.Br_Taken, m1.Br_Count);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
